// File: rtl/tas_pkt_ctrl.sv
// Packet sequencer for the temperature averaging receiver (clk_50 domain).
// Optional per-packet statistics outputs are enabled by defining TAS_PKT_STATS_EN.
module tas_pkt_ctrl #(
  parameter int              DW     = 8,
  parameter int              NBYTES = 4,
  parameter logic [DW-1:0]   HDR_T0 = 8'hA5,
  parameter logic [DW-1:0]   HDR_T1 = 8'hC3
) (
  input  logic          clk_50,
  input  logic          reset_n,
  input  logic          serial_data,
  input  logic          data_ena,
  input  logic          fifo_full,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_wdata,
  output logic          ovf,
  output logic          busy
`ifdef TAS_PKT_STATS_EN
  ,
  output logic [7:0]    temp_pkt_cnt,
  output logic [7:0]    skip_pkt_cnt
`endif
);

  localparam int LW = $clog2(NBYTES);
  localparam int BW = $clog2(DW);
  localparam int AW = DW + LW;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);
  localparam logic [LW-1:0] LAST_BYTE = LW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_SKIP = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  logic [BW-1:0] bit_cnt_r;
  logic [DW-1:0] shift_r;
  logic [DW-1:0] byte_s;
  logic          byte_done_s;

  state_t        state_r, state_s;
  logic [AW-1:0] acc_r, acc_s;
  logic [LW-1:0] bcnt_r, bcnt_s;
  logic          wr_s, ovf_s;
  logic [DW-1:0] wdata_s;

  // Deserialiser: bit counter and LSB-first shift register
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else if (data_ena) begin
      shift_r[bit_cnt_r] <= serial_data;
      bit_cnt_r          <= bit_cnt_r + BW'(1);
    end else begin
      bit_cnt_r <= '0;
    end
  end

  // Completed byte is formed combinationally so the FSM acts on the 8th-bit edge
  always_comb begin
    byte_s         = shift_r;
    byte_s[DW-1]   = serial_data;
    byte_done_s    = data_ena && (bit_cnt_r == LAST_BIT);
  end

  // Next-state, accumulator and push decisions
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    bcnt_s  = bcnt_r;
    wr_s    = 1'b0;
    ovf_s   = 1'b0;
    wdata_s = fifo_wdata;
    case (state_r)
      ST_HDR: begin
        if (byte_done_s) begin
          bcnt_s = '0;
          if ((byte_s == HDR_T0) || (byte_s == HDR_T1)) begin
            state_s = ST_DATA;
            acc_s   = '0;
          end else begin
            state_s = ST_SKIP;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (byte_done_s) begin
          acc_s = acc_r + {{LW{1'b0}}, byte_s};
          if (bcnt_r == LAST_BYTE) begin
            state_s = ST_PUSH;
          end else begin
            bcnt_s = bcnt_r + LW'(1);
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_SKIP: begin
        // Payload of foreign packets is ignored, even bytes that look like headers
        if (byte_done_s) begin
          if (bcnt_r == LAST_BYTE) begin
            state_s = ST_HDR;
          end else begin
            bcnt_s = bcnt_r + LW'(1);
          end
        end else begin
          state_s = ST_SKIP;
        end
      end
      ST_PUSH: begin
        state_s = ST_HDR;
        if (fifo_full) begin
          ovf_s = 1'b1;
        end else begin
          wr_s    = 1'b1;
          wdata_s = acc_r[AW-1:LW];
        end
      end
      default: begin
        state_s = ST_HDR;
      end
    endcase
  end

  // FSM state, datapath and registered outputs
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_r    <= ST_HDR;
      acc_r      <= '0;
      bcnt_r     <= '0;
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      bcnt_r     <= bcnt_s;
      fifo_wr    <= wr_s;
      fifo_wdata <= wdata_s;
      ovf        <= ovf_s;
      busy       <= (state_s != ST_HDR);
    end
  end

`ifdef TAS_PKT_STATS_EN
  logic skip_done_s;

  // A foreign packet completes on its last payload byte
  always_comb begin
    skip_done_s = (state_r == ST_SKIP) && byte_done_s && (bcnt_r == LAST_BYTE);
  end

  // Wrapping packet statistics
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      temp_pkt_cnt <= 8'd0;
      skip_pkt_cnt <= 8'd0;
    end else begin
      if (state_r == ST_PUSH) begin
        temp_pkt_cnt <= temp_pkt_cnt + 8'd1;
      end else begin
        temp_pkt_cnt <= temp_pkt_cnt;
      end
      if (skip_done_s) begin
        skip_pkt_cnt <= skip_pkt_cnt + 8'd1;
      end else begin
        skip_pkt_cnt <= skip_pkt_cnt;
      end
    end
  end
`endif

endmodule
